// File: rtl/uart_ram_loader_pkg.sv
// Shared definitions for the UART RAM loader: command and response codes,
// FSM state encodings, response-kind enum and the byte-lane select helper.
package loader_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_READ  = 8'h02;
   localparam logic [7:0] CMD_RUN   = 8'h03;
   localparam logic [7:0] CMD_HALT  = 8'h04;

   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_ADDR     = 4'd1;
   localparam logic [3:0] S_LEN      = 4'd2;
   localparam logic [3:0] S_WR_DATA  = 4'd3;
   localparam logic [3:0] S_WR_PULSE = 4'd4;
   localparam logic [3:0] S_RD_REQ   = 4'd5;
   localparam logic [3:0] S_RD_WAIT  = 4'd6;
   localparam logic [3:0] S_RD_SEND  = 4'd7;
   localparam logic [3:0] S_RESP     = 4'd8;
   localparam logic [3:0] S_SUM      = 4'd9;

   // What happens after the response byte in S_RESP has been sent.
   typedef enum logic [1:0] {
      RESP_DONE = 2'd0,   // back to idle
      RESP_SUM  = 2'd1,   // follow with the checksum byte
      RESP_RUN  = 2'd2    // release the CPU, then idle
   } resp_kind_t;

   // Byte lane inside a RAM word for a byte address; lanes is XLEN/8.
   function automatic logic [2:0] lane_sel(input logic [2:0] addr_lo, input int lanes);
      lane_sel = addr_lo & 3'(lanes - 1);
   endfunction

endpackage

// File: rtl/uart_ram_loader_if.sv
// Byte-stream and RAM loader-port bundle for uart_ram_loader.
//   rx_*  : byte stream from uart_rx (valid/ready)
//   tx_*  : byte stream to uart_tx (valid/ready)
//   ram_* : RAM loader port, byte address, lane byte-enables
// master = the loader, slave = the uart/RAM side.
interface uart_ram_loader_if #(
   parameter int XLEN = 32
);
   logic [7:0]        rx_data_i;
   logic              rx_vld_i;
   logic              rx_rdy_o;
   logic [7:0]        tx_data_o;
   logic              tx_vld_o;
   logic              tx_rdy_i;
   logic              ram_en_o;
   logic              ram_we_o;
   logic [XLEN-1:0]   ram_addr_o;
   logic [XLEN-1:0]   ram_wr_data_o;
   logic [XLEN/8-1:0] ram_wr_byte_en_o;
   logic [XLEN-1:0]   ram_rd_data_i;

   modport master (
      input  rx_data_i, rx_vld_i, tx_rdy_i, ram_rd_data_i,
      output rx_rdy_o, tx_data_o, tx_vld_o,
             ram_en_o, ram_we_o, ram_addr_o, ram_wr_data_o, ram_wr_byte_en_o
   );

   modport slave (
      output rx_data_i, rx_vld_i, tx_rdy_i, ram_rd_data_i,
      input  rx_rdy_o, tx_data_o, tx_vld_o,
             ram_en_o, ram_we_o, ram_addr_o, ram_wr_data_o, ram_wr_byte_en_o
   );
endinterface

// File: rtl/uart_ram_loader_rx_timeout.sv
// Inter-byte receive timeout. Down-counter reloaded on clr_i, decremented
// while en_i; expire_o pulses on the cycle the count reaches terminal, so
// the owner reacts exactly TIMEOUT_CYC cycles after the last clear.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   clr_i          : reload (rx handshake), has priority over expiry
//   en_i           : count enable
//   expire_o       : one-cycle timeout pulse
module rx_timeout #(
   parameter int TIMEOUT_CYC = 1200000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt <= CW'(TIMEOUT_CYC);
      end else if (clr_i) begin
         cnt <= CW'(TIMEOUT_CYC);
      end else if (en_i && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire_o = en_i && !clr_i && (cnt == CW'(1));
endmodule

// File: rtl/uart_ram_loader.sv
// UART loader/debug bridge: parses WRITE/READ/RUN/HALT commands from the rx
// byte stream, drives the RAM loader port, answers with data/ACK/NAK/checksum
// on the tx stream and owns the CPU reset.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   bus            : rx/tx byte streams and RAM port (master side)
//   cpu_rst_n_o    : 0 holds the CPU halted
//   busy_o         : high whenever the FSM is not idle
//
// state      | meaning
// S_IDLE     | waiting for a command byte
// S_ADDR     | collecting little-endian address bytes
// S_LEN      | collecting little-endian length bytes
// S_WR_DATA  | waiting for the next write data byte
// S_WR_PULSE | one-cycle RAM write of the byte
// S_RD_REQ   | one-cycle RAM read strobe
// S_RD_WAIT  | waiting out the RAM read latency
// S_RD_SEND  | presenting the read byte on tx
// S_RESP     | sending ACK/NAK
// S_SUM      | sending the checksum
module uart_ram_loader
   import loader_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int LEN_W       = 16,
   parameter int TIMEOUT_CYC = 1200000,
   parameter int RD_LAT      = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   uart_ram_loader_if.master bus,
   output logic              cpu_rst_n_o,
   output logic              busy_o
);
   localparam int AB = XLEN / 8;
   localparam int LB = LEN_W / 8;
   localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [AB-1:0] BE_ONE = AB'(1);

   logic [3:0]       state;
   resp_kind_t       resp_kind;
   logic             is_read;
   logic             cpu_run;
   logic             rdy_q;
   logic [XLEN-1:0]  addr;
   logic [LEN_W-1:0] len;
   logic [2:0]       hdr_cnt;
   logic [7:0]       sum;
   logic [7:0]       tx_byte;
   logic [7:0]       wr_byte;
   logic [WW-1:0]    wait_cnt;

   logic             rx_hs, tx_hs, tmo_en, tmo;
   logic             ram_en, ram_we;
   logic [2:0]       lane;
   logic [7:0]       rd_byte;
   logic [LEN_W-1:0] len_full;

   assign rx_hs  = bus.rx_vld_i && bus.rx_rdy_o;
   assign tx_hs  = bus.tx_vld_o && bus.tx_rdy_i;
   assign tmo_en = (state == S_ADDR) || (state == S_LEN) || (state == S_WR_DATA);
   assign lane   = lane_sel(addr[2:0], AB);
   // len is cleared at the command byte, so OR-ing in each byte assembles it.
   assign len_full = len | (LEN_W'(bus.rx_data_i) << {hdr_cnt, 3'b000});

   always_comb begin
      rd_byte = '0;
      for (int i = 0; i < AB; i++) begin
         if (lane == 3'(i)) rd_byte = bus.ram_rd_data_i[8*i +: 8];
      end
   end

   rx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx_timeout (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .clr_i    (rx_hs),
      .en_i     (tmo_en),
      .expire_o (tmo)
   );

   assign ram_en = (state == S_WR_PULSE) || (state == S_RD_REQ);
   assign ram_we = (state == S_WR_PULSE);

   assign bus.ram_en_o         = ram_en;
   assign bus.ram_we_o         = ram_we;
   assign bus.ram_addr_o       = ram_en ? addr : '0;
   assign bus.ram_wr_data_o    = ram_we ? {AB{wr_byte}} : '0;
   assign bus.ram_wr_byte_en_o = ram_we ? (BE_ONE << lane) : '0;

   // rdy_q keeps rx_rdy_o low through reset and the first cycle after it.
   assign bus.rx_rdy_o  = rdy_q && tmo_en || rdy_q && (state == S_IDLE);
   assign bus.tx_vld_o  = (state == S_RESP) || (state == S_SUM) || (state == S_RD_SEND);
   assign bus.tx_data_o = tx_byte;
   assign busy_o        = (state != S_IDLE);
   assign cpu_rst_n_o   = cpu_run;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state     <= S_IDLE;
         resp_kind <= RESP_DONE;
         is_read   <= 1'b0;
         cpu_run   <= 1'b0;
         rdy_q     <= 1'b0;
         addr      <= '0;
         len       <= '0;
         hdr_cnt   <= '0;
         sum       <= '0;
         tx_byte   <= '0;
         wr_byte   <= '0;
         wait_cnt  <= '0;
      end else begin
         rdy_q <= 1'b1;
         case (state)
            S_IDLE: if (rx_hs) begin
               addr    <= '0;
               len     <= '0;
               hdr_cnt <= '0;
               sum     <= '0;
               case (bus.rx_data_i)
                  CMD_WRITE, CMD_READ: begin
                     if (cpu_run) begin
                        tx_byte   <= NAK;
                        resp_kind <= RESP_DONE;
                        state     <= S_RESP;
                     end else begin
                        is_read <= (bus.rx_data_i == CMD_READ);
                        state   <= S_ADDR;
                     end
                  end
                  CMD_RUN: begin
                     tx_byte   <= ACK;
                     resp_kind <= RESP_RUN;
                     state     <= S_RESP;
                  end
                  CMD_HALT: begin
                     cpu_run   <= 1'b0;
                     tx_byte   <= ACK;
                     resp_kind <= RESP_DONE;
                     state     <= S_RESP;
                  end
                  default: begin
                     tx_byte   <= NAK;
                     resp_kind <= RESP_DONE;
                     state     <= S_RESP;
                  end
               endcase
            end
            S_ADDR: begin
               if (rx_hs) begin
                  addr <= addr | (XLEN'(bus.rx_data_i) << {hdr_cnt, 3'b000});
                  if (hdr_cnt == 3'(AB - 1)) begin
                     hdr_cnt <= '0;
                     state   <= S_LEN;
                  end else begin
                     hdr_cnt <= hdr_cnt + 1'b1;
                  end
               end else if (tmo) begin
                  tx_byte   <= NAK;
                  resp_kind <= RESP_DONE;
                  state     <= S_RESP;
               end
            end
            S_LEN: begin
               if (rx_hs) begin
                  len <= len_full;
                  if (hdr_cnt == 3'(LB - 1)) begin
                     if (len_full == '0) begin
                        tx_byte   <= ACK;
                        resp_kind <= RESP_SUM;
                        state     <= S_RESP;
                     end else begin
                        state <= is_read ? S_RD_REQ : S_WR_DATA;
                     end
                  end else begin
                     hdr_cnt <= hdr_cnt + 1'b1;
                  end
               end else if (tmo) begin
                  tx_byte   <= NAK;
                  resp_kind <= RESP_DONE;
                  state     <= S_RESP;
               end
            end
            S_WR_DATA: begin
               if (rx_hs) begin
                  wr_byte <= bus.rx_data_i;
                  state   <= S_WR_PULSE;
               end else if (tmo) begin
                  tx_byte   <= NAK;
                  resp_kind <= RESP_DONE;
                  state     <= S_RESP;
               end
            end
            S_WR_PULSE: begin
               addr <= addr + 1'b1;
               sum  <= sum + wr_byte;
               len  <= len - 1'b1;
               if (len == LEN_W'(1)) begin
                  tx_byte   <= ACK;
                  resp_kind <= RESP_SUM;
                  state     <= S_RESP;
               end else begin
                  state <= S_WR_DATA;
               end
            end
            S_RD_REQ: begin
               wait_cnt <= WW'(RD_LAT - 1);
               state    <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (wait_cnt == '0) begin
                  tx_byte <= rd_byte;
                  state   <= S_RD_SEND;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            S_RD_SEND: if (tx_hs) begin
               sum  <= sum + tx_byte;
               addr <= addr + 1'b1;
               len  <= len - 1'b1;
               if (len == LEN_W'(1)) begin
                  tx_byte   <= ACK;
                  resp_kind <= RESP_SUM;
                  state     <= S_RESP;
               end else begin
                  state <= S_RD_REQ;
               end
            end
            S_RESP: if (tx_hs) begin
               case (resp_kind)
                  RESP_SUM: begin
                     tx_byte <= sum;
                     state   <= S_SUM;
                  end
                  RESP_RUN: begin
                     cpu_run <= 1'b1;
                     state   <= S_IDLE;
                  end
                  default: state <= S_IDLE;
               endcase
            end
            S_SUM: if (tx_hs) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
